prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader_pkg.sv | 32 +++
 rtl/prog_loader_byte_packer.sv | 46 ++++
 rtl/prog_loader.sv | 172 +++++++++++++++++
 tb/tb_prog_loader.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: memory geometry, run length,
// address/counter widths and the sequencing state encoding.
package prog_loader_pkg;

    localparam int IM_WORDS_DEF   = 32;
    localparam int DM_BYTES_DEF   = 128;
    localparam int RUN_CYCLES_DEF = 17;

    localparam int IM_AW  = 5;
    localparam int DM_AW  = 7;
    localparam int LEN_W  = 6;
    localparam int RUN_CW = 5;

    typedef logic [IM_AW-1:0]  im_addr_t;
    typedef logic [DM_AW-1:0]  dm_addr_t;
    typedef logic [LEN_W-1:0]  len_t;
    typedef logic [RUN_CW-1:0] run_cnt_t;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        LOAD,
        RUN,
        DONE
    } state_t;

    // Requested load length saturated at the instruction-memory depth.
    function automatic len_t clamp_len(input len_t req, input len_t limit);
        return (req > limit) ? limit : req;
    endfunction

endpackage

// File: rtl/prog_loader_byte_packer.sv
// Collects four handshaked bytes big-endian into one 32-bit word and
// presents it with a registered one-cycle valid pulse.
module byte_packer
    import prog_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic [7:0]  data,
    input  logic        fire,
    output logic        last,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  idx;
    logic [23:0] acc;

    assign last = (idx == 2'd3);

    // A clear discards any partial word left over from an interrupted load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx        <= 2'd0;
            acc        <= 24'd0;
            word       <= 32'd0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            if (clear) begin
                idx <= 2'd0;
                acc <= 24'd0;
            end else if (fire) begin
                if (last) begin
                    word       <= {acc, data};
                    word_valid <= 1'b1;
                    idx        <= 2'd0;
                end else begin
                    acc <= {acc[15:0], data};
                    idx <= idx + 2'd1;
                end
            end
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Load-and-run sequencer: clears both memories, streams program bytes into
// instruction memory, then releases the CPU for a fixed run and flags the dump.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int IM_WORDS   = IM_WORDS_DEF,
    parameter int DM_BYTES   = DM_BYTES_DEF,
    parameter int RUN_CYCLES = RUN_CYCLES_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [LEN_W-1:0] load_len_i,
    input  logic [7:0]       byte_i,
    input  logic             byte_valid_i,
    output logic             byte_ready_o,
    output logic             im_we_o,
    output logic [IM_AW-1:0] im_addr_o,
    output logic [31:0]      im_data_o,
    output logic             dm_we_o,
    output logic [DM_AW-1:0] dm_addr_o,
    output logic [7:0]       dm_data_o,
    output logic             cpu_rst_n_o,
    output logic             snap_o,
    output logic             done_o
);

    localparam dm_addr_t DM_LAST  = dm_addr_t'(DM_BYTES - 1);
    localparam dm_addr_t IM_AREA  = dm_addr_t'(IM_WORDS);
    localparam len_t     IM_LEN   = len_t'(IM_WORDS);
    localparam run_cnt_t RUN_LAST = run_cnt_t'(RUN_CYCLES - 1);

    state_t   state;
    len_t     len_q;
    len_t     words_q;
    run_cnt_t run_cnt;
    im_addr_t im_addr_q;
    dm_addr_t dm_addr_q;
    logic     im_we_q;
    logic     dm_we_q;
    logic     ready_q;
    logic     cpu_rst_n_q;
    logic     snap_q;
    logic     done_q;

    logic        start_ok;
    logic        fire;
    logic        last_byte;
    logic        word_valid;
    logic [31:0] word;
    dm_addr_t    dm_next;

    assign start_ok = start_i && ((state == IDLE) || (state == DONE));
    assign fire     = byte_valid_i && ready_q;
    assign dm_next  = dm_addr_q + dm_addr_t'(1);

    byte_packer u_packer (
        .clk        (clk_i),
        .rst_n      (rst_i),
        .clear      (start_ok),
        .data       (byte_i),
        .fire       (fire),
        .last       (last_byte),
        .word_valid (word_valid),
        .word       (word)
    );

    // The data-memory address doubles as the clear counter; the first
    // IM_WORDS clear cycles also zero instruction memory.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state       <= IDLE;
            len_q       <= '0;
            words_q     <= '0;
            run_cnt     <= '0;
            im_addr_q   <= '0;
            dm_addr_q   <= '0;
            im_we_q     <= 1'b0;
            dm_we_q     <= 1'b0;
            ready_q     <= 1'b0;
            cpu_rst_n_q <= 1'b0;
            snap_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            snap_q <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start_i) begin
                        state       <= CLR;
                        len_q       <= clamp_len(load_len_i, IM_LEN);
                        words_q     <= '0;
                        run_cnt     <= '0;
                        dm_we_q     <= 1'b1;
                        dm_addr_q   <= '0;
                        im_we_q     <= 1'b1;
                        im_addr_q   <= '0;
                        ready_q     <= 1'b0;
                        cpu_rst_n_q <= 1'b0;
                        done_q      <= 1'b0;
                    end
                end
                CLR: begin
                    if (dm_addr_q == DM_LAST) begin
                        dm_we_q   <= 1'b0;
                        dm_addr_q <= '0;
                        im_we_q   <= 1'b0;
                        im_addr_q <= '0;
                        if (len_q != '0) begin
                            state   <= LOAD;
                            ready_q <= 1'b1;
                        end else begin
                            state       <= RUN;
                            cpu_rst_n_q <= 1'b1;
                            run_cnt     <= '0;
                            snap_q      <= (RUN_LAST == '0);
                        end
                    end else begin
                        dm_addr_q <= dm_next;
                        im_we_q   <= (dm_next < IM_AREA);
                        im_addr_q <= (dm_next < IM_AREA) ? im_addr_t'(dm_next) : '0;
                    end
                end
                LOAD: begin
                    // Ready drops with the fourth byte so nothing is taken
                    // while the assembled word is being written.
                    if (fire && last_byte) begin
                        ready_q <= 1'b0;
                    end
                    if (word_valid) begin
                        im_addr_q <= im_addr_q + im_addr_t'(1);
                        words_q   <= words_q + len_t'(1);
                        if (words_q + len_t'(1) == len_q) begin
                            state       <= RUN;
                            cpu_rst_n_q <= 1'b1;
                            run_cnt     <= '0;
                            snap_q      <= (RUN_LAST == '0);
                            im_addr_q   <= '0;
                        end else begin
                            ready_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (run_cnt == RUN_LAST) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                    end else begin
                        run_cnt <= run_cnt + run_cnt_t'(1);
                        snap_q  <= (run_cnt + run_cnt_t'(1) == RUN_LAST);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Word writes come straight from the packer's registered pulse so they
    // land exactly one cycle after the fourth byte handshake.
    assign byte_ready_o = ready_q;
    assign im_we_o      = im_we_q | word_valid;
    assign im_addr_o    = im_addr_q;
    assign im_data_o    = word_valid ? word : 32'd0;
    assign dm_we_o      = dm_we_q;
    assign dm_addr_o    = dm_addr_q;
    assign dm_data_o    = 8'd0;
    assign cpu_rst_n_o  = cpu_rst_n_q;
    assign snap_o       = snap_q;
    assign done_o       = done_q;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: random byte streams and valid patterns
// compared against a transaction-level model of clear, load and run timing.
module tb_prog_loader;

    logic        clk_i;
    logic        rst_i;
    logic        start_i;
    logic [5:0]  load_len_i;
    logic [7:0]  byte_i;
    logic        byte_valid_i;
    logic        byte_ready_o;
    logic        im_we_o;
    logic [4:0]  im_addr_o;
    logic [31:0] im_data_o;
    logic        dm_we_o;
    logic [6:0]  dm_addr_o;
    logic [7:0]  dm_data_o;
    logic        cpu_rst_n_o;
    logic        snap_o;
    logic        done_o;

    int compared   = 0;
    int mismatched = 0;

    logic [7:0]  stim_q[$];
    logic [31:0] written[$];

    prog_loader dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .load_len_i   (load_len_i),
        .byte_i       (byte_i),
        .byte_valid_i (byte_valid_i),
        .byte_ready_o (byte_ready_o),
        .im_we_o      (im_we_o),
        .im_addr_o    (im_addr_o),
        .im_data_o    (im_data_o),
        .dm_we_o      (dm_we_o),
        .dm_addr_o    (dm_addr_o),
        .dm_data_o    (dm_data_o),
        .cpu_rst_n_o  (cpu_rst_n_o),
        .snap_o       (snap_o),
        .done_o       (done_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check_output(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] all_outs();
        return 128'({byte_ready_o, im_we_o, im_addr_o, im_data_o, dm_we_o, dm_addr_o,
                     dm_data_o, cpu_rst_n_o, snap_o, done_o});
    endfunction

    task automatic fill_random(input int n);
        stim_q.delete();
        for (int i = 0; i < n; i++) stim_q.push_back(8'($urandom));
    endtask

    // One full start/clear/load/run sequence, entered and left on a falling edge.
    task automatic apply_stimulus(input int len, input int valid_pct, input int abort_bytes, input bit poke_run);
        logic [7:0]  offered[$];
        logic [7:0]  orig[$];
        int          accepted, eff, widx, fourth_k, rise_k, last_write_k, exp_rise;
        bit          finished, v;
        logic [31:0] exp_word;
        eff          = (len > 32) ? 32 : len;
        offered      = stim_q;
        orig         = stim_q;
        accepted     = 0;
        widx         = 0;
        fourth_k     = -10;
        rise_k       = -1;
        last_write_k = -1;
        finished     = 1'b0;
        written.delete();
        start_i      = 1'b1;
        load_len_i   = 6'(len);
        byte_valid_i = 1'b0;
        for (int k = 1; k <= 4000 && !finished; k++) begin
            @(negedge clk_i);
            start_i = 1'b0;
            if (k <= 128) begin
                check_output("clr",
                    128'({dm_we_o, dm_addr_o, dm_data_o, im_we_o,
                          im_we_o ? {im_addr_o, im_data_o} : 37'd0,
                          byte_ready_o, cpu_rst_n_o, snap_o, done_o}),
                    128'({1'b1, 7'(k - 1), 8'h00, (k <= 32),
                          (k <= 32) ? {5'(k - 1), 32'h0} : 37'd0, 4'b0000}));
            end else begin
                if (rise_k < 0 && cpu_rst_n_o === 1'b1) begin
                    rise_k   = k;
                    exp_rise = (eff == 0) ? 129 : last_write_k + 1;
                    check_output("run_entry", 128'({k, widx}), 128'({exp_rise, eff}));
                end
                if (rise_k > 0) begin
                    check_output("run",
                        128'({cpu_rst_n_o, im_we_o, dm_we_o, byte_ready_o, snap_o, done_o}),
                        128'({4'b1000, k == rise_k + 16, k >= rise_k + 17}));
                    if (k == rise_k + 17) finished = 1'b1;
                    if (poke_run && k == rise_k + 5) begin
                        start_i    = 1'b1;
                        load_len_i = 6'($urandom);
                    end
                end else begin
                    check_output("load",
                        128'({dm_we_o, snap_o, done_o, byte_ready_o, im_we_o}),
                        128'({3'b000, k != fourth_k + 1, k == fourth_k + 1}));
                    if (im_we_o === 1'b1) begin
                        exp_word = {orig[4*widx], orig[4*widx+1], orig[4*widx+2], orig[4*widx+3]};
                        check_output("im_write", 128'({k, im_addr_o, im_data_o}),
                                     128'({fourth_k + 1, 5'(widx), exp_word}));
                        written.push_back(im_data_o);
                        widx++;
                        last_write_k = k;
                    end
                end
            end
            if (!finished) begin
                v = (offered.size() > 0) && (int'($urandom_range(99)) < valid_pct);
                byte_valid_i = v;
                byte_i       = v ? offered[0] : 8'($urandom);
                if (v && byte_ready_o === 1'b1) begin
                    void'(offered.pop_front());
                    accepted++;
                    if (accepted % 4 == 0) fourth_k = k;
                    if (abort_bytes > 0 && accepted == abort_bytes) begin
                        @(posedge clk_i);
                        #2 rst_i = 1'b0;
                        #1 check_output("reset_async", all_outs(), 128'(0));
                        @(negedge clk_i);
                        rst_i        = 1'b1;
                        byte_valid_i = 1'b0;
                        return;
                    end
                end
            end
        end
        byte_valid_i = 1'b0;
        check_output("finished", 128'(finished), 128'(1));
        check_output("bytes_accepted", 128'(accepted), 128'(4 * eff));
        check_output("words_written", 128'(widx), 128'(eff));
    endtask

    initial begin
        int n;
        rst_i        = 1'b1;
        start_i      = 1'b0;
        load_len_i   = 6'd0;
        byte_i       = 8'd0;
        byte_valid_i = 1'b0;
        #3 rst_i = 1'b0;
        #4 check_output("reset_state", all_outs(), 128'(0));
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        check_output("idle_state", all_outs(), 128'(0));

        stim_q = {8'h00, 8'h22, 8'h08, 8'h20, 8'h8C, 8'h01, 8'h00, 8'h04};
        apply_stimulus(2, 100, 0, 1'b0);
        check_output("word0", 128'(written[0]), 128'(32'h00220820));
        check_output("word1", 128'(written[1]), 128'(32'h8C010004));

        stim_q.delete();
        apply_stimulus(0, 100, 0, 1'b1);

        fill_random(160);
        apply_stimulus(40, 100, 0, 1'b0);

        for (int r = 0; r < 3; r++) begin
            n = int'($urandom_range(1, 12));
            fill_random(4 * n + 3);
            apply_stimulus(n, 40, 0, 1'b0);
        end

        fill_random(16);
        apply_stimulus(4, 100, 6, 1'b0);
        byte_valid_i = 1'b1;
        byte_i       = 8'hAA;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            check_output("post_reset_idle",
                128'({im_we_o, dm_we_o, byte_ready_o, cpu_rst_n_o, snap_o, done_o}), 128'(0));
        end
        byte_valid_i = 1'b0;
        fill_random(12);
        apply_stimulus(3, 70, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
